// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register file write-port arbiter between the in-order pipeline and a long-latency result FIFO
// Optional macro: RF_WRITE_ARBITER_FWD_EN adds query_fwd_valid/query_fwd_data (youngest pending FIFO data for query_addr).
module rf_write_arbiter #(
    parameter int XLEN          = 64,
    parameter int REGISTER_SIZE = 5,
    parameter int FIFO_DEPTH    = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_wr_en,
    input  logic [REGISTER_SIZE-1:0] pipe_wr_addr,
    input  logic [XLEN-1:0]          pipe_wr_data,
    input  logic                     lu_valid,
    output logic                     lu_ready,
    input  logic [REGISTER_SIZE-1:0] lu_addr,
    input  logic [XLEN-1:0]          lu_data,
    output logic                     pipe_stall,
    output logic                     rf_writeback_enable,
    output logic [REGISTER_SIZE-1:0] rf_writeback_addr,
    output logic [XLEN-1:0]          rf_writeback_data,
    input  logic [REGISTER_SIZE-1:0] query_addr,
    output logic                     query_pending
`ifdef RF_WRITE_ARBITER_FWD_EN
    ,
    output logic                     query_fwd_valid,
    output logic [XLEN-1:0]          query_fwd_data
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    logic [REGISTER_SIZE-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [XLEN-1:0]          r_fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]    r_fifo_valid;
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_count;
    state_t                   r_state;
    logic [STV_W-1:0]         r_starve;
    logic                     r_wb_en;
    logic [REGISTER_SIZE-1:0] r_wb_addr;
    logic [XLEN-1:0]          r_wb_data;

    logic                     w_push;
    logic                     w_pipe_req;
    logic                     w_fifo_nonempty;
    logic                     w_grant_fifo;
    logic                     w_grant_pipe;
    logic [CNT_W-1:0]         w_count_next;
    logic                     w_query_hit;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // lu_ready comes only from the registered count so it never depends on lu_valid
    assign lu_ready        = (r_count < CNT_W'(FIFO_DEPTH));
    // Results for x0 are accepted but never stored
    assign w_push          = lu_valid & lu_ready & (lu_addr != '0);
    assign w_pipe_req      = pipe_wr_en & (pipe_wr_addr != '0);
    assign w_fifo_nonempty = (r_count != '0);
    // FORCE takes the port unconditionally; otherwise the pipeline wins and the FIFO fills idle slots
    assign w_grant_fifo    = w_fifo_nonempty & ((r_state == ST_FORCE) | ~w_pipe_req);
    assign w_grant_pipe    = (r_state != ST_FORCE) & w_pipe_req;
    assign w_count_next    = r_count + CNT_W'(w_push) - CNT_W'(w_grant_fifo);

    assign pipe_stall          = (r_state == ST_FORCE);
    assign rf_writeback_enable = r_wb_en;
    assign rf_writeback_addr   = r_wb_addr;
    assign rf_writeback_data   = r_wb_data;

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_fifo_valid <= '0;
        end else begin
            if (w_push) begin
                r_fifo_addr[r_wr_ptr]  <= lu_addr;
                r_fifo_data[r_wr_ptr]  <= lu_data;
                r_fifo_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr               <= ptr_inc(r_wr_ptr);
            end
            if (w_grant_fifo) begin
                r_fifo_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr               <= ptr_inc(r_rd_ptr);
            end
            r_count <= w_count_next;
        end
    end

    // Starvation FSM: counts cycles the FIFO head is passed over and forces a one-cycle drain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_starve <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_starve <= '0;
                    if (w_push) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_grant_fifo) begin
                        r_starve <= '0;
                        r_state  <= (w_count_next == '0) ? ST_IDLE : ST_WAIT;
                    end else begin
                        r_starve <= r_starve + STV_W'(1);
                        if (r_starve >= STV_W'(STARVE_LIMIT - 1)) begin
                            r_state <= ST_FORCE;
                        end
                    end
                end
                ST_FORCE: begin
                    r_starve <= '0;
                    r_state  <= (w_count_next == '0) ? ST_IDLE : ST_WAIT;
                end
                default: begin
                    r_starve <= '0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    // Register the granted write so it reaches the register file one cycle after grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_en   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else begin
            r_wb_en <= w_grant_fifo | w_grant_pipe;
            if (w_grant_fifo) begin
                r_wb_addr <= r_fifo_addr[r_rd_ptr];
                r_wb_data <= r_fifo_data[r_rd_ptr];
            end else if (w_grant_pipe) begin
                r_wb_addr <= pipe_wr_addr;
                r_wb_data <= pipe_wr_data;
            end
        end
    end

    // Hazard lookup: any valid FIFO entry targeting the queried register
    always_comb begin
        w_query_hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (r_fifo_valid[i] && (r_fifo_addr[i] == query_addr)) begin
                w_query_hit = 1'b1;
            end
        end
    end

    assign query_pending = w_query_hit & (query_addr != '0);

`ifdef RF_WRITE_ARBITER_FWD_EN
    logic [PTR_W-1:0] w_scan_ptr;
    logic [XLEN-1:0]  w_fwd_data;

    // Walk oldest to youngest so the last match is the youngest pending value
    always_comb begin
        w_fwd_data = '0;
        w_scan_ptr = r_rd_ptr;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (r_fifo_valid[w_scan_ptr] && (r_fifo_addr[w_scan_ptr] == query_addr)) begin
                w_fwd_data = r_fifo_data[w_scan_ptr];
            end
            w_scan_ptr = ptr_inc(w_scan_ptr);
        end
    end

    assign query_fwd_valid = query_pending;
    assign query_fwd_data  = w_fwd_data;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wr_en;
    logic [4:0]  pipe_wr_addr;
    logic [63:0] pipe_wr_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_addr;
    logic [63:0] lu_data;
    logic        pipe_stall;
    logic        rf_writeback_enable;
    logic [4:0]  rf_writeback_addr;
    logic [63:0] rf_writeback_data;
    logic [4:0]  query_addr;
    logic        query_pending;
`ifdef RF_WRITE_ARBITER_FWD_EN
    logic        query_fwd_valid;
    logic [63:0] query_fwd_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    rf_write_arbiter dut (
        .clk                 (clk),
        .rst                 (rst),
        .pipe_wr_en          (pipe_wr_en),
        .pipe_wr_addr        (pipe_wr_addr),
        .pipe_wr_data        (pipe_wr_data),
        .lu_valid            (lu_valid),
        .lu_ready            (lu_ready),
        .lu_addr             (lu_addr),
        .lu_data             (lu_data),
        .pipe_stall          (pipe_stall),
        .rf_writeback_enable (rf_writeback_enable),
        .rf_writeback_addr   (rf_writeback_addr),
        .rf_writeback_data   (rf_writeback_data),
        .query_addr          (query_addr),
        .query_pending       (query_pending)
`ifdef RF_WRITE_ARBITER_FWD_EN
        ,
        .query_fwd_valid     (query_fwd_valid),
        .query_fwd_data      (query_fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_wr_en   = 1'b0;
        pipe_wr_addr = '0;
        pipe_wr_data = '0;
        lu_valid     = 1'b0;
        lu_addr      = '0;
        lu_data      = '0;
        query_addr   = '0;
    endtask

    task automatic quiet_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        query_addr = 5'd5;
        #1;
        n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_lu_ready got=%b exp=1", lu_ready); end
        n_checks++; if (pipe_stall !== 1'b0) begin n_fail++; $display("FAIL reset_pipe_stall got=%b exp=0", pipe_stall); end
        n_checks++; if (rf_writeback_enable !== 1'b0) begin n_fail++; $display("FAIL reset_wb_en got=%b exp=0", rf_writeback_enable); end
        n_checks++; if (rf_writeback_addr !== 5'd0) begin n_fail++; $display("FAIL reset_wb_addr got=%0d exp=0", rf_writeback_addr); end
        n_checks++; if (rf_writeback_data !== 64'd0) begin n_fail++; $display("FAIL reset_wb_data got=%h exp=0", rf_writeback_data); end
        n_checks++; if (query_pending !== 1'b0) begin n_fail++; $display("FAIL reset_query_pending got=%b exp=0", query_pending); end
        rst = 1'b0;
        query_addr = '0;
    endtask

    task automatic test_lu_single();
        quiet_reset();
        lu_valid = 1'b1; lu_addr = 5'd5; lu_data = 64'hAA;
        n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got=%b exp=1", lu_ready); end
        tick();
        lu_valid = 1'b0;
        query_addr = 5'd5;
        #1;
        n_checks++; if (query_pending !== 1'b1) begin n_fail++; $display("FAIL single_pending got=%b exp=1", query_pending); end
        n_checks++; if (rf_writeback_enable !== 1'b0) begin n_fail++; $display("FAIL single_early_wb got=%b exp=0", rf_writeback_enable); end
        tick();
        n_checks++; if (rf_writeback_enable !== 1'b1) begin n_fail++; $display("FAIL single_wb_en got=%b exp=1", rf_writeback_enable); end
        n_checks++; if (rf_writeback_addr !== 5'd5) begin n_fail++; $display("FAIL single_wb_addr got=%0d exp=5", rf_writeback_addr); end
        n_checks++; if (rf_writeback_data !== 64'hAA) begin n_fail++; $display("FAIL single_wb_data got=%h exp=aa", rf_writeback_data); end
        n_checks++; if (query_pending !== 1'b0) begin n_fail++; $display("FAIL single_pending_clear got=%b exp=0", query_pending); end
        tick();
        n_checks++; if (rf_writeback_enable !== 1'b0) begin n_fail++; $display("FAIL single_wb_drop got=%b exp=0", rf_writeback_enable); end
        n_checks++; if (pipe_stall !== 1'b0) begin n_fail++; $display("FAIL single_idle_stall got=%b exp=0", pipe_stall); end
        query_addr = '0;
    endtask

    task automatic test_starve();
        int          exp_a [9] = '{1, 2, 3, 4, 5, 9, 6, 7, 8};
        logic [4:0]  got_a [16];
        logic [63:0] got_d [16];
        logic [63:0] exp_d;
        int          idx = 1;
        int          nw = 0;
        int          nstall = 0;
        int          stall_pos = -1;
        logic        stall_now;
        quiet_reset();
        for (int c = 0; c < 14; c++) begin
            pipe_wr_en   = (idx <= 8);
            pipe_wr_addr = 5'(idx);
            pipe_wr_data = 64'h100 + 64'(idx);
            lu_valid     = (c == 0);
            lu_addr      = 5'd9;
            lu_data      = 64'h55;
            stall_now    = pipe_stall;
            if (stall_now) begin
                nstall++;
                stall_pos = c;
            end
            tick();
            if (rf_writeback_enable) begin
                if (nw < 16) begin
                    got_a[nw] = rf_writeback_addr;
                    got_d[nw] = rf_writeback_data;
                end
                nw++;
            end
            if (!stall_now && idx <= 8) idx++;
        end
        idle_inputs();
        n_checks++; if (nw !== 9) begin n_fail++; $display("FAIL starve_write_count got=%0d exp=9", nw); end
        n_checks++; if (nstall !== 1) begin n_fail++; $display("FAIL starve_stall_count got=%0d exp=1", nstall); end
        n_checks++; if (stall_pos !== 5) begin n_fail++; $display("FAIL starve_stall_cycle got=%0d exp=5", stall_pos); end
        for (int i = 0; i < 9; i++) begin
            if (i < nw) begin
                exp_d = (exp_a[i] == 9) ? 64'h55 : 64'h100 + 64'(exp_a[i]);
                n_checks++; if (got_a[i] !== 5'(exp_a[i])) begin n_fail++; $display("FAIL starve_order[%0d] got=%0d exp=%0d", i, got_a[i], exp_a[i]); end
                n_checks++; if (got_d[i] !== exp_d) begin n_fail++; $display("FAIL starve_data[%0d] got=%h exp=%h", i, got_d[i], exp_d); end
            end
        end
    endtask

    task automatic test_full();
        logic [4:0]  got_a [8];
        logic [63:0] got_d [8];
        logic [63:0] exp_d [3] = '{64'hA1, 64'hA2, 64'hA3};
        int          j = 0;
        int          nlu = 0;
        int          nstall = 0;
        int          pa = 1;
        logic        acc;
        logic        stall_now;
        quiet_reset();
        for (int c = 0; c < 22; c++) begin
            pipe_wr_en   = (c < 18);
            pipe_wr_addr = 5'(pa);
            pipe_wr_data = 64'h200 + 64'(c);
            lu_valid     = (j < 3);
            lu_addr      = 5'(10 + j);
            lu_data      = (j < 3) ? exp_d[j] : 64'h0;
            acc          = lu_valid && lu_ready;
            stall_now    = pipe_stall;
            if (stall_now) nstall++;
            tick();
            if (acc) begin
                j++;
                if (j == 2) begin
                    n_checks++; if (lu_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_low got=%b exp=0", lu_ready); end
                end
            end
            if (rf_writeback_enable && rf_writeback_addr >= 5'd10) begin
                if (nlu < 8) begin
                    got_a[nlu] = rf_writeback_addr;
                    got_d[nlu] = rf_writeback_data;
                end
                nlu++;
            end
            if (!stall_now) pa = (pa == 3) ? 1 : pa + 1;
        end
        idle_inputs();
        n_checks++; if (j !== 3) begin n_fail++; $display("FAIL full_accepted got=%0d exp=3", j); end
        n_checks++; if (nlu !== 3) begin n_fail++; $display("FAIL full_lu_writes got=%0d exp=3", nlu); end
        n_checks++; if (nstall !== 3) begin n_fail++; $display("FAIL full_stalls got=%0d exp=3", nstall); end
        for (int i = 0; i < 3; i++) begin
            if (i < nlu) begin
                n_checks++; if (got_a[i] !== 5'(10 + i)) begin n_fail++; $display("FAIL full_addr[%0d] got=%0d exp=%0d", i, got_a[i], 10 + i); end
                n_checks++; if (got_d[i] !== exp_d[i]) begin n_fail++; $display("FAIL full_data[%0d] got=%h exp=%h", i, got_d[i], exp_d[i]); end
            end
        end
    endtask

    task automatic test_x0();
        quiet_reset();
        lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 64'hFF;
        pipe_wr_en = 1'b1; pipe_wr_addr = 5'd0; pipe_wr_data = 64'h77;
        tick();
        idle_inputs();
        n_checks++; if (rf_writeback_enable !== 1'b0) begin n_fail++; $display("FAIL x0_wb_first got=%b exp=0", rf_writeback_enable); end
        tick();
        n_checks++; if (rf_writeback_enable !== 1'b0) begin n_fail++; $display("FAIL x0_wb_second got=%b exp=0", rf_writeback_enable); end
        n_checks++; if (pipe_stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall got=%b exp=0", pipe_stall); end
        lu_valid = 1'b1; lu_addr = 5'd3; lu_data = 64'h33;
        tick();
        idle_inputs();
        pipe_wr_en = 1'b1; pipe_wr_addr = 5'd0; pipe_wr_data = 64'h99;
        tick();
        n_checks++; if (rf_writeback_enable !== 1'b1) begin n_fail++; $display("FAIL x0_free_wb_en got=%b exp=1", rf_writeback_enable); end
        n_checks++; if (rf_writeback_addr !== 5'd3) begin n_fail++; $display("FAIL x0_free_wb_addr got=%0d exp=3", rf_writeback_addr); end
        n_checks++; if (rf_writeback_data !== 64'h33) begin n_fail++; $display("FAIL x0_free_wb_data got=%h exp=33", rf_writeback_data); end
        idle_inputs();
        tick();
        n_checks++; if (rf_writeback_enable !== 1'b0) begin n_fail++; $display("FAIL x0_free_after got=%b exp=0", rf_writeback_enable); end
    endtask

    task automatic test_query_and_reset();
        quiet_reset();
        pipe_wr_en = 1'b1; pipe_wr_addr = 5'd1; pipe_wr_data = 64'h1;
        lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 64'h11;
        tick();
        lu_data = 64'h22;
        tick();
        lu_valid = 1'b0;
        n_checks++; if (lu_ready !== 1'b0) begin n_fail++; $display("FAIL query_full_ready got=%b exp=0", lu_ready); end
        query_addr = 5'd7;
        #1;
        n_checks++; if (query_pending !== 1'b1) begin n_fail++; $display("FAIL query_hit got=%b exp=1", query_pending); end
`ifdef RF_WRITE_ARBITER_FWD_EN
        n_checks++; if (query_fwd_valid !== 1'b1) begin n_fail++; $display("FAIL query_fwd_valid got=%b exp=1", query_fwd_valid); end
        n_checks++; if (query_fwd_data !== 64'h22) begin n_fail++; $display("FAIL query_fwd_data got=%h exp=22", query_fwd_data); end
`endif
        query_addr = 5'd8;
        #1;
        n_checks++; if (query_pending !== 1'b0) begin n_fail++; $display("FAIL query_miss got=%b exp=0", query_pending); end
        query_addr = 5'd7;
        tick();
        tick();
        n_checks++; if (pipe_stall !== 1'b0) begin n_fail++; $display("FAIL prerst_stall got=%b exp=0", pipe_stall); end
        rst = 1'b1;
        tick();
        n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got=%b exp=1", lu_ready); end
        n_checks++; if (pipe_stall !== 1'b0) begin n_fail++; $display("FAIL midrst_stall got=%b exp=0", pipe_stall); end
        n_checks++; if (rf_writeback_enable !== 1'b0) begin n_fail++; $display("FAIL midrst_wb_en got=%b exp=0", rf_writeback_enable); end
        n_checks++; if (query_pending !== 1'b0) begin n_fail++; $display("FAIL midrst_pending got=%b exp=0", query_pending); end
        rst = 1'b0;
        pipe_wr_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (rf_writeback_enable !== 1'b0) begin n_fail++; $display("FAIL postrst_wb[%0d] got=%b exp=0", c, rf_writeback_enable); end
            n_checks++; if (pipe_stall !== 1'b0) begin n_fail++; $display("FAIL postrst_stall[%0d] got=%b exp=0", c, pipe_stall); end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_lu_single();
        test_starve();
        test_full();
        test_x0();
        test_query_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter XLEN, default 64, register data width.
REQ-002 Parameter REGISTER_SIZE, default 5, register address width.
REQ-003 Parameter FIFO_DEPTH, default 2, pending long-latency result entries.
REQ-004 Parameter STARVE_LIMIT, default 4, max cycles a FIFO head waits before forced drain.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 pipe_wr_en  in  1  in-order pipeline writeback request.
REQ-008 pipe_wr_addr  in  REGISTER_SIZE  pipeline destination register.
REQ-009 pipe_wr_data  in  XLEN  pipeline write data.
REQ-010 lu_valid  in  1  long-latency unit (mul/div) result valid.
REQ-011 lu_ready  out  1  arbiter can accept a long-latency result.
REQ-012 lu_addr  in  REGISTER_SIZE  long-latency destination register.
REQ-013 lu_data  in  XLEN  long-latency result data.
REQ-014 pipe_stall  out  1  holds the pipeline for one cycle during a forced drain.
REQ-015 rf_writeback_enable / rf_writeback_addr / rf_writeback_data  out  1 / REGISTER_SIZE / XLEN  register file write port.
REQ-016 query_addr  in  REGISTER_SIZE  decode-stage source register for hazard check.
REQ-017 query_pending  out  1  query_addr has an unwritten result in the FIFO.

Function
REQ-018 Long-latency result SHALL be accepted on a cycle with lu_valid=1 and lu_ready=1 and pushed to FIFO tail.
REQ-019 lu_ready SHALL be 1 iff FIFO count < FIFO_DEPTH, derived from registered count only.
REQ-020 Accepted result with lu_addr=0 SHALL be consumed and discarded, not pushed.
REQ-021 Grant per cycle: FORCE state -> FIFO head; else pipe_wr_en=1 with pipe_wr_addr!=0 -> pipeline; else FIFO non-empty -> FIFO head; else none.
REQ-022 pipe_wr_en with pipe_wr_addr=0 SHALL produce no write and SHALL leave the port free for the FIFO head.
REQ-023 Granted write SHALL appear on rf_writeback_* exactly one cycle after grant; rf_writeback_enable=0 on cycles with no grant.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 States: IDLE (FIFO empty), WAIT (FIFO non-empty), FORCE (one-cycle drain).
REQ-026 IDLE -> WAIT on push; WAIT -> IDLE when last entry pops with no push; WAIT -> FORCE when starve counter reaches STARVE_LIMIT; FORCE -> WAIT or IDLE per post-pop count.
REQ-027 Starve counter SHALL increment each WAIT cycle the head is not popped, clear on every pop and in IDLE.
REQ-028 pipe_stall SHALL be 1 only in FORCE; pipe_wr_en SHALL be ignored that cycle (upstream re-presents it).
REQ-029 query_pending SHALL be combinational: 1 iff query_addr!=0 and matches any valid FIFO entry address.

Reset
REQ-030 On rst: FIFO empty, state IDLE, starve counter 0, lu_ready=1, pipe_stall=0, rf_writeback_enable=0, rf_writeback_addr=0, rf_writeback_data=0, query_pending=0.
REQ-031 rst mid-operation SHALL discard all pending FIFO entries and any registered-but-unissued write.

Configuration
REQ-032 Macro RF_WRITE_ARBITER_FWD_EN defined: extra outputs query_fwd_valid (1) and query_fwd_data (XLEN) SHALL return the youngest matching FIFO entry's data, query_fwd_valid=query_pending.
REQ-033 Macro undefined: forwarding ports and logic SHALL be absent; decode stalls on query_pending only.

Verification
REQ-034 Reset then lu push x5=0xAA with no pipe traffic -> rf_writeback x5=0xAA two cycles after acceptance, state returns IDLE.
REQ-035 Pipe writes x1..x8 every cycle, lu push x9=0x55 -> x9 held for 4 cycles, pipe_stall=1 one cycle, x9 written, x1..x8 all written in order.
REQ-036 Two lu pushes with continuous pipe traffic -> lu_ready=0 after second push; third lu_valid held until a pop, no data lost.
REQ-037 lu push x0=0xFF and pipe write x0 -> no rf_writeback_enable pulse, FIFO count stays 0.
REQ-038 FIFO holds x7=0x11 then x7=0x22, query_addr=7 -> query_pending=1; with RF_WRITE_ARBITER_FWD_EN query_fwd_data=0x22.
REQ-039 rst asserted with 2 FIFO entries and FORCE pending -> next cycle lu_ready=1, pipe_stall=0, no writes issued.
